// File: rtl/mar_agu.sv
// Memory address register / address generation unit.
// Load, add, step and sequential burst addressing for the memory port.
module mar_agu #(
  parameter int ADDR    = 8,
  parameter int OP      = 8,
  parameter int BURST_W = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 mar_load,
  input  logic                 mar_add,
  input  logic                 mar_inc,
  input  logic                 mar_dec,
  input  logic [OP+ADDR-1:0]   mar_bus,
  input  logic                 burst_start,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic                 mem_ready,
  output logic [ADDR-1:0]      address,
  output logic                 busy,
  output logic                 burst_done,
  output logic                 wrap
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t               state, state_n;
  logic [BURST_W-1:0]   count, count_n;
  logic [ADDR-1:0]      addr_n;
  logic                 busy_n;
  logic                 done_n;
  logic                 wrap_n;

  logic [ADDR:0]        sum_add;
  logic [ADDR:0]        sum_inc;
  logic [ADDR:0]        diff_dec;
  logic                 unused_op;

  // Top bit of each result is the carry/borrow out of the address.
  assign sum_add  = {1'b0, address}
                  + {1'b0, mar_bus[ADDR-1:0]};
  assign sum_inc  = {1'b0, address}
                  + {{ADDR{1'b0}}, 1'b1};
  assign diff_dec = {1'b0, address}
                  - {{ADDR{1'b0}}, 1'b1};

  assign unused_op = ^mar_bus[OP+ADDR-1:ADDR];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      count      <= '0;
      address    <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      address    <= addr_n;
      busy       <= busy_n;
      burst_done <= done_n;
      wrap       <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    addr_n  = address;
    busy_n  = busy;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mar_load) begin
          addr_n = mar_bus[ADDR-1:0];
        end else if (mar_add) begin
          addr_n = sum_add[ADDR-1:0];
          wrap_n = sum_add[ADDR];
        end else if (mar_inc) begin
          addr_n = sum_inc[ADDR-1:0];
          wrap_n = sum_inc[ADDR];
        end else if (mar_dec) begin
          addr_n = diff_dec[ADDR-1:0];
          wrap_n = diff_dec[ADDR];
        end
        // The burst begins from whatever address the op above produced.
        if (burst_start) begin
          state_n = BURST;
          count_n = burst_len;
          busy_n  = 1'b1;
        end
      end
      BURST: begin
        if (mem_ready) begin
          if (count != '0) begin
            addr_n  = sum_inc[ADDR-1:0];
            wrap_n  = sum_inc[ADDR];
            count_n = count - BURST_W'(1);
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
